sobel_frame_ctrl: RTL

Frame sequencer for the 3x3 Sobel stencil datapath. On a `start` pulse it streams a WIDTH x HEIGHT greyscale frame from image memory into the datapath's (2*WIDTH+3)-entry line buffer, one pixel per cycle. It qualifies which shifts produce a legal interior window, suppressing the fill phase and the row-wrap windows. It also generates write enables and dense addresses for the edge-map memory. It sits between the image RAM, the stencil datapath and the output RAM.

---
 rtl/sobel_pkg.sv | 27 ++
 rtl/sobel_win_tracker.sv | 49 ++++
 rtl/sobel_frame_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel frame sequencer: FSM state encoding,
// default frame geometry and the fill/output sizes derived from it.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH  = 482;
  localparam int DEF_HEIGHT = 482;

  // Shifts needed before the line buffer holds a full 3x3 window.
  function automatic int fill_len(input int width);
    return 2 * width + 2;
  endfunction

  function automatic int out_pixels(input int width, input int height);
    return (width - 2) * (height - 2);
  endfunction

  localparam int FILL_LEN   = fill_len(DEF_WIDTH);
  localparam int OUT_PIXELS = out_pixels(DEF_WIDTH, DEF_HEIGHT);

endpackage

// File: rtl/sobel_win_tracker.sv
// Qualifies each line-buffer shift as a legal interior window; one cycle from shift to flag.
// No backpressure: every shift_en is evaluated, clear restarts the fill and column tracking.
module sobel_win_tracker
  import sobel_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic shift_en,
  output logic win
);

  localparam logic [ADDR_W-1:0] FILL       = ADDR_W'(fill_len(WIDTH));
  localparam logic [ADDR_W-1:0] COL_MAX    = ADDR_W'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] COL_LEGAL  = ADDR_W'(WIDTH - 3);
  localparam logic [ADDR_W-1:0] ONE        = ADDR_W'(1);

  logic [ADDR_W-1:0] fill_cnt;
  logic [ADDR_W-1:0] col;
  logic              filled;

  assign filled = (fill_cnt == FILL);

  // col tracks (t mod WIDTH) for the window whose newest pixel is shifting now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt <= '0;
      col      <= '0;
      win      <= 1'b0;
    end else if (clear) begin
      fill_cnt <= '0;
      col      <= '0;
      win      <= 1'b0;
    end else begin
      win <= shift_en && filled && (col <= COL_LEGAL);
      if (shift_en) begin
        if (!filled) begin
          fill_cnt <= fill_cnt + ONE;
        end else begin
          col <= (col == COL_MAX) ? '0 : col + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Streams a WIDTH x HEIGHT frame into the stencil line buffer and addresses the edge-map RAM.
// Read at n, shift at n+1, window at n+2; hold gates new reads in the same cycle.
module sobel_frame_ctrl
  import sobel_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              lb_clear,
  output logic              shift_en,
  output logic              win_valid,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  state_t state;
  logic   rd_act;

  // hold must kill the read in the cycle it is raised, so it bypasses the register.
  assign rd_en = rd_act && !hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_act   <= 1'b0;
      rd_addr  <= '0;
      lb_clear <= 1'b0;
      shift_en <= 1'b0;
      wr_addr  <= '0;
    end else begin
      lb_clear <= 1'b0;
      done     <= 1'b0;
      shift_en <= rd_en;
      if (win_valid) begin
        wr_addr <= wr_addr + ONE;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            rd_act   <= 1'b1;
            rd_addr  <= '0;
            wr_addr  <= '0;
            lb_clear <= 1'b1;
          end
        end
        FETCH: begin
          if (rd_en) begin
            if (rd_addr == LAST_ADDR) begin
              state  <= DRAIN;
              rd_act <= 1'b0;
            end else begin
              rd_addr <= rd_addr + ONE;
            end
          end
        end
        DRAIN: begin
          // With no shift in flight, the window now on win_valid is the last one.
          if (!shift_en) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sobel_win_tracker #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_win_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (lb_clear),
    .shift_en (shift_en),
    .win      (win_valid)
  );

endmodule
